// File: rtl/rata_mr.sv
// ---------------------------------------------------------------------------
// rata_mr : multi-region attestation-region (AR) monitor
//
// Watches the MSP430 program counter, CPU writes and DMA writes. The AR is
// split into NUM_AR equal sub-regions, each with its own dirty bit. A
// saturating counter tracks how many cycles wrote into the AR since the last
// completed attestation. The FSM drives the LMT update strobe, and a reset
// stretcher holds hw_reset high for RST_PULSE cycles after leaving KILL. Any
// write into the LMT sends the FSM to KILL.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   pc         in   current program counter
//   data_wr    in   CPU write strobe
//   data_addr  in   CPU write address
//   dma_en     in   DMA access strobe
//   dma_addr   in   DMA address
//   upLMT      out  LMT update enable (registered)
//   hw_reset   out  device reset request (registered)
//   dirty      out  per-sub-region modified flags
//   mod_cnt    out  saturating count of AR-write cycles
//   state_o    out  current FSM state
// ---------------------------------------------------------------------------
module rata_mr #(
   parameter int                 ADDR_W         = 16,
   parameter int                 NUM_AR         = 4,
   parameter logic [ADDR_W-1:0]  AR_BASE        = 16'hE000,
   parameter logic [ADDR_W-1:0]  AR_REGION_SIZE = 16'h0800,
   parameter logic [ADDR_W-1:0]  LMT_BASE       = 16'h0040,
   parameter logic [ADDR_W-1:0]  LMT_SIZE       = 16'h0020,
   parameter logic [ADDR_W-1:0]  SMEM_BASE      = 16'hA000,
   parameter logic [ADDR_W-1:0]  SMEM_SIZE      = 16'h4000,
   parameter logic [ADDR_W-1:0]  RESET_HANDLER  = 16'h0000,
   parameter logic [ADDR_W-1:0]  AUTH_HANDLER   = SMEM_BASE + 16'h0010,
   parameter int                 RST_PULSE      = 4,
   parameter int                 CNT_W          = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic              data_wr,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic              dma_en,
   input  logic [ADDR_W-1:0] dma_addr,
   output logic              upLMT,
   output logic              hw_reset,
   output logic [NUM_AR-1:0] dirty,
   output logic [CNT_W-1:0]  mod_cnt,
   output logic [2:0]        state_o
);

   localparam logic [ADDR_W-1:0] LAST_SMEM_ADDR = SMEM_BASE + SMEM_SIZE - 2;
   localparam logic [ADDR_W-1:0] LAST_LMT       = LMT_BASE + LMT_SIZE - 2;

   // Region bounds are evaluated in a wider space so the end of the last
   // sub-region (which may equal 2^ADDR_W) does not wrap to zero.
   localparam int AW = ADDR_W + 6;

   localparam int RC_W = $clog2(RST_PULSE + 1);
   localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_PULSE);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      MOD    = 3'd0,
      NOTMOD = 3'd1,
      UPDATE = 3'd2,
      KILL   = 3'd3,
      ATTEST = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              uplmt_q, uplmt_d;
   logic              hw_reset_q, hw_reset_d;
   logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic [NUM_AR-1:0] dirty_q, dirty_d;
   logic [CNT_W-1:0]  mod_cnt_q, mod_cnt_d;

   logic [NUM_AR-1:0] hit_cpu, hit_dma, hit;
   logic              ar_wr;
   logic              lmt_hit;
   logic              kill_now;
   logic              att_done;

   // Sub-regions are tracked at word granularity: the last inclusive word
   // of sub-region i is base+size-2, so its odd byte (base+size-1) belongs
   // to the same sub-region. Hence the exclusive upper bound base+size.
   function automatic logic in_region(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       idx);
      logic [AW-1:0] a;
      logic [AW-1:0] lo;
      logic [AW-1:0] hi;
      a  = AW'(addr);
      lo = AW'(AR_BASE) + AW'(idx) * AW'(AR_REGION_SIZE);
      hi = lo + AW'(AR_REGION_SIZE);
      return (a >= lo) && (a < hi);
   endfunction

   function automatic logic in_lmt(input logic [ADDR_W-1:0] addr);
      return (addr >= LMT_BASE) && (addr <= LAST_LMT);
   endfunction

   always_comb begin
      hit_cpu = '0;
      hit_dma = '0;
      for (int unsigned i = 0; i < NUM_AR; i++) begin
         hit_cpu[i] = data_wr && in_region(data_addr, i);
         hit_dma[i] = dma_en  && in_region(dma_addr, i);
      end
   end

   assign hit     = hit_cpu | hit_dma;
   assign ar_wr   = |hit;
   assign lmt_hit = (data_wr && in_lmt(data_addr)) || (dma_en && in_lmt(dma_addr));

   assign kill_now = (state_q == KILL) || lmt_hit;
   // Completion is judged on the PC alone so that a write landing on the
   // final SW-Att cycle restarts the window with only that write dirty.
   assign att_done = (state_q == ATTEST) && (pc == LAST_SMEM_ADDR) && !lmt_hit;

   // Next-state logic: earlier branches take priority.
   always_comb begin
      state_d = state_q;
      if (lmt_hit) begin
         state_d = KILL;
      end else if ((state_q != KILL) && ar_wr) begin
         state_d = MOD;
      end else begin
         case (state_q)
            KILL:    if (pc == RESET_HANDLER) state_d = MOD;
            MOD:     if (pc == AUTH_HANDLER)  state_d = UPDATE;
            UPDATE:  if (pc != AUTH_HANDLER)  state_d = ATTEST;
            ATTEST: begin
               if (pc == LAST_SMEM_ADDR)    state_d = NOTMOD;
               else if (pc == AUTH_HANDLER) state_d = UPDATE;
            end
            NOTMOD:  state_d = NOTMOD;
            default: state_d = KILL;
         endcase
      end
   end

   always_comb begin
      uplmt_d = (((state_q == MOD) || (state_q == ATTEST)) && (pc == AUTH_HANDLER))
                || (state_q == UPDATE);

      // Stretcher reloads while killed so hw_reset outlasts KILL by RST_PULSE.
      rst_cnt_d = rst_cnt_q;
      if (kill_now) begin
         rst_cnt_d = RC_LOAD;
      end else if (rst_cnt_q != '0) begin
         rst_cnt_d = rst_cnt_q - 1'b1;
      end
      hw_reset_d = (rst_cnt_d != '0);

      dirty_d = dirty_q | hit;
      if (kill_now) begin
         dirty_d = '1;
      end else if (att_done) begin
         dirty_d = hit;
      end

      mod_cnt_d = mod_cnt_q;
      if (kill_now) begin
         mod_cnt_d = '0;
      end else if (att_done) begin
         mod_cnt_d = ar_wr ? CNT_W'(1) : '0;
      end else if (ar_wr && (mod_cnt_q != CNT_MAX)) begin
         mod_cnt_d = mod_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= KILL;
         uplmt_q    <= 1'b0;
         hw_reset_q <= 1'b1;
         rst_cnt_q  <= RC_LOAD;
         dirty_q    <= '1;
         mod_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         uplmt_q    <= uplmt_d;
         hw_reset_q <= hw_reset_d;
         rst_cnt_q  <= rst_cnt_d;
         dirty_q    <= dirty_d;
         mod_cnt_q  <= mod_cnt_d;
      end
   end

   assign upLMT    = uplmt_q;
   assign hw_reset = hw_reset_q;
   assign dirty    = dirty_q;
   assign mod_cnt  = mod_cnt_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_rata_mr.sv
module tb_rata_mr;

   localparam int NUM_AR = 4;
   localparam int AR_B   = 'hE000;
   localparam int AR_SZ  = 'h0800;
   localparam int AUTH   = 'hA010;
   localparam int LASTS  = 'hDFFE;
   localparam int ST_MOD = 0, ST_NOTMOD = 1, ST_UPDATE = 2, ST_KILL = 3, ST_ATTEST = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] pc;
   logic        data_wr;
   logic [15:0] data_addr;
   logic        dma_en;
   logic [15:0] dma_addr;
   logic        upLMT;
   logic        hw_reset;
   logic [3:0]  dirty;
   logic [7:0]  mod_cnt;
   logic [2:0]  state_o;

   int checks   = 0;
   int failures = 0;

   // Reference model: abstract state of the monitor.
   int       m_state;
   bit       m_up;
   bit       m_hw;
   int       m_rc;
   bit [3:0] m_dirty;
   int       m_mod;

   always #5 clk = ~clk;

   rata_mr dut (
      .clk(clk), .reset_n(reset_n), .pc(pc),
      .data_wr(data_wr), .data_addr(data_addr),
      .dma_en(dma_en), .dma_addr(dma_addr),
      .upLMT(upLMT), .hw_reset(hw_reset), .dirty(dirty),
      .mod_cnt(mod_cnt), .state_o(state_o)
   );

   function automatic int region(input int a);
      int r;
      if (a < AR_B) return -1;
      r = (a - AR_B) / AR_SZ;
      return (r < NUM_AR) ? r : -1;
   endfunction

   function automatic bit is_lmt(input int a);
      return (a >= 'h40) && (a <= 'h5E);
   endfunction

   task automatic model_reset();
      m_state = ST_KILL; m_up = 0; m_hw = 1; m_rc = 4; m_dirty = 4'hF; m_mod = 0;
   endtask

   // Drive one cycle of inputs, advance the model over the clock edge and
   // return #1 after the edge so outputs can be sampled.
   task automatic step(input int p, input bit w, input int wa, input bit d, input int da);
      bit [3:0] h;
      bit arw, lmt, kill, att;
      int ns, nrc, nmod;
      bit nup;
      bit [3:0] nd;
      h = 4'b0;
      if (w && region(wa) >= 0) h[region(wa)] = 1'b1;
      if (d && region(da) >= 0) h[region(da)] = 1'b1;
      arw  = (h != 0);
      lmt  = (w && is_lmt(wa)) || (d && is_lmt(da));
      kill = (m_state == ST_KILL) || lmt;
      att  = (m_state == ST_ATTEST) && (p == LASTS) && !lmt;
      ns = m_state;
      if (lmt) ns = ST_KILL;
      else if (m_state != ST_KILL && arw) ns = ST_MOD;
      else if (m_state == ST_KILL && p == 0) ns = ST_MOD;
      else if (m_state == ST_MOD && p == AUTH) ns = ST_UPDATE;
      else if (m_state == ST_UPDATE && p != AUTH) ns = ST_ATTEST;
      else if (m_state == ST_ATTEST && p == LASTS) ns = ST_NOTMOD;
      else if (m_state == ST_ATTEST && p == AUTH) ns = ST_UPDATE;
      nup  = ((m_state == ST_MOD || m_state == ST_ATTEST) && p == AUTH) || m_state == ST_UPDATE;
      nrc  = kill ? 4 : (m_rc > 0 ? m_rc - 1 : 0);
      nd   = kill ? 4'hF : (att ? h : (m_dirty | h));
      nmod = kill ? 0 : (att ? (arw ? 1 : 0) : (arw ? (m_mod < 255 ? m_mod + 1 : 255) : m_mod));
      pc = 16'(p); data_wr = w; data_addr = 16'(wa); dma_en = d; dma_addr = 16'(da);
      @(posedge clk);
      #1;
      m_state = ns; m_up = nup; m_rc = nrc; m_hw = (nrc != 0); m_dirty = nd; m_mod = nmod;
   endtask

   task automatic idle(input int p);
      step(p, 0, 0, 0, 0);
   endtask

   task automatic do_attest();
      idle(AUTH); idle('hA012); idle(LASTS);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; pc = 0; data_wr = 0; data_addr = 0; dma_en = 0; dma_addr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL reset_state got=%0d exp=3", state_o); end
      checks++; if (hw_reset !== 1'b1) begin failures++; $display("FAIL reset_hw got=%0b exp=1", hw_reset); end
      checks++; if (dirty !== 4'hF) begin failures++; $display("FAIL reset_dirty got=%b exp=1111", dirty); end
      checks++; if (mod_cnt !== 8'd0) begin failures++; $display("FAIL reset_modcnt got=%0d exp=0", mod_cnt); end
      checks++; if (upLMT !== 1'b0) begin failures++; $display("FAIL reset_uplmt got=%0b exp=0", upLMT); end
      reset_n = 1'b1;
      idle(0);
      checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL kill_exit_state got=%0d exp=0", state_o); end
      checks++; if (dirty !== 4'hF || upLMT !== 1'b0) begin failures++; $display("FAIL kill_exit_flags got=%b/%0b exp=1111/0", dirty, upLMT); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (hw_reset !== (i < 4)) begin failures++; $display("FAIL hw_stretch cyc=%0d got=%0b exp=%0b", i, hw_reset, (i < 4)); end
         if (i < 4) idle(0);
      end
   endtask

   task automatic test_attest();
      idle(AUTH);
      checks++; if (upLMT !== 1'b1 || state_o !== 3'd2) begin failures++; $display("FAIL att_update got=%0b/%0d exp=1/2", upLMT, state_o); end
      idle('hA012);
      checks++; if (upLMT !== 1'b1 || state_o !== 3'd4) begin failures++; $display("FAIL att_attest got=%0b/%0d exp=1/4", upLMT, state_o); end
      idle(LASTS);
      checks++; if (upLMT !== 1'b0 || state_o !== 3'd1) begin failures++; $display("FAIL att_done got=%0b/%0d exp=0/1", upLMT, state_o); end
      checks++; if (dirty !== 4'h0 || mod_cnt !== 8'd0) begin failures++; $display("FAIL att_clear got=%b/%0d exp=0000/0", dirty, mod_cnt); end
   endtask

   task automatic test_multi_write();
      step('h1000, 1, 'hE800, 1, 'hF7FE);
      checks++; if (state_o !== 3'd0 || dirty !== 4'b0110 || mod_cnt !== 8'd1) begin failures++; $display("FAIL dual_hit got=%0d/%b/%0d exp=0/0110/1", state_o, dirty, mod_cnt); end
      step('h1000, 1, 'hE7FF, 0, 0);
      checks++; if (dirty !== 4'b0111 || mod_cnt !== 8'd2) begin failures++; $display("FAIL odd_edge got=%b/%0d exp=0111/2", dirty, mod_cnt); end
      step('h1000, 1, 'hE000, 0, 0);
      checks++; if (dirty !== 4'b0111 || mod_cnt !== 8'd3) begin failures++; $display("FAIL base_hit got=%b/%0d exp=0111/3", dirty, mod_cnt); end
      step('h1000, 1, 'h0100, 1, 'hDFFE);
      checks++; if (dirty !== 4'b0111 || mod_cnt !== 8'd3 || state_o !== 3'd0) begin failures++; $display("FAIL no_hit got=%b/%0d/%0d exp=0111/3/0", dirty, mod_cnt, state_o); end
   endtask

   task automatic test_lmt_kill();
      int highs;
      do_attest();
      checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL pre_kill_state got=%0d exp=1", state_o); end
      step('h1000, 0, 0, 1, 'h0050);
      checks++; if (state_o !== 3'd3 || hw_reset !== 1'b1) begin failures++; $display("FAIL lmt_kill got=%0d/%0b exp=3/1", state_o, hw_reset); end
      checks++; if (dirty !== 4'hF || mod_cnt !== 8'd0) begin failures++; $display("FAIL lmt_kill_regs got=%b/%0d exp=1111/0", dirty, mod_cnt); end
      idle('h1234);
      checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL kill_hold got=%0d exp=3", state_o); end
      idle(0); idle('h1000); idle('h1000);
      step('h1000, 1, 'h0040, 0, 0);
      checks++; if (state_o !== 3'd3 || hw_reset !== 1'b1) begin failures++; $display("FAIL rekill got=%0d/%0b exp=3/1", state_o, hw_reset); end
      idle(0);
      highs = 0;
      for (int i = 0; i < 10 && hw_reset === 1'b1; i++) begin
         highs++;
         idle('h1000);
      end
      checks++; if (highs !== 4) begin failures++; $display("FAIL rearm_len got=%0d exp=4", highs); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) step('h1000, 1, 'hE100, 0, 0);
      checks++; if (mod_cnt !== 8'd255 || state_o !== 3'd0) begin failures++; $display("FAIL saturate got=%0d/%0d exp=255/0", mod_cnt, state_o); end
      step('h1000, 0, 0, 1, 'hE102);
      checks++; if (mod_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", mod_cnt); end
   endtask

   task automatic test_abort();
      idle(AUTH); idle('hA012);
      checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL abort_setup got=%0d exp=4", state_o); end
      step(LASTS, 1, 'hFFFE, 0, 0);
      checks++; if (state_o !== 3'd0 || dirty !== 4'b1000 || mod_cnt !== 8'd1) begin failures++; $display("FAIL abort_last got=%0d/%b/%0d exp=0/1000/1", state_o, dirty, mod_cnt); end
   endtask

   task automatic test_async_reset();
      step('h1000, 1, 'hE900, 0, 0);
      reset_n = 1'b0;
      model_reset();
      #2;
      checks++; if (state_o !== 3'd3 || hw_reset !== 1'b1 || upLMT !== 1'b0) begin failures++; $display("FAIL async_ctrl got=%0d/%0b/%0b exp=3/1/0", state_o, hw_reset, upLMT); end
      checks++; if (dirty !== 4'hF || mod_cnt !== 8'd0) begin failures++; $display("FAIL async_regs got=%b/%0d exp=1111/0", dirty, mod_cnt); end
      reset_n = 1'b1;
   endtask

   function automatic int rand_addr();
      int s = $urandom_range(0, 99);
      if (s < 70) return $urandom_range(AR_B, 'hFFFF);
      if (s < 75) return 'h40 + 2 * $urandom_range(0, 15);
      return $urandom_range(0, 'hFFFF);
   endfunction

   function automatic int rand_pc();
      int s = $urandom_range(0, 99);
      if (s < 10) return 0;
      if (s < 30) return AUTH;
      if (s < 45) return 'hA012;
      if (s < 60) return LASTS;
      return $urandom_range(0, 'hFFFF);
   endfunction

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 800; i++) begin
         step(rand_pc(), ($urandom_range(0, 99) < 30), rand_addr(),
              ($urandom_range(0, 99) < 20), rand_addr());
         checks++;
         if (state_o !== 3'(m_state) || upLMT !== m_up || hw_reset !== m_hw ||
             dirty !== m_dirty || mod_cnt !== 8'(m_mod)) begin
            failures++; bad++;
            if (bad <= 10)
               $display("FAIL random cyc=%0d got st=%0d up=%0b hw=%0b d=%b m=%0d exp st=%0d up=%0b hw=%0b d=%b m=%0d",
                        i, state_o, upLMT, hw_reset, dirty, mod_cnt,
                        m_state, m_up, m_hw, m_dirty, m_mod);
         end
      end
   endtask

   initial begin
      test_reset();
      test_attest();
      test_multi_write();
      test_lmt_kill();
      test_saturation();
      test_abort();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
